// File: rtl/cnn_image_sequencer.sv
// Runs N-image classification passes on the CNN core: core reset, pixel stream, wait, score.
// Optional WAIT watchdog enabled by defining SEQ_TIMEOUT_EN.
module cnn_image_sequencer #(
  parameter int PIX_PER_IMG = 784,
  parameter int MAX_IMG     = 1000,
  parameter int ADDR_W      = 20,
  parameter int CNT_W       = 10,
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_img,
  output logic              busy,
  output logic              done,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [7:0]        pix_data,
  output logic [CNT_W-1:0]  lbl_addr,
  input  logic [3:0]        lbl_data,
  output logic              cnn_rst_n,
  output logic [7:0]        cnn_data,
  input  logic              valid_out,
  input  logic [3:0]        decision,
  output logic              res_valid,
  output logic              res_hit,
  output logic [CNT_W-1:0]  res_idx,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  img_cnt,
  output logic              timeout_err
);

  localparam int CYC_W = $clog2(TIMEOUT + PIX_PER_IMG + RST_CYC + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CNN_RST, S_STREAM, S_DRAIN, S_WAIT, S_SCORE, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CYC_W-1:0]  cyc_q;
  logic [CNT_W-1:0]  n_q, idx_q, hit_q, img_q;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        lbl_q, dec_q;
  logic              to_q, rd_d1, cnn_rst_q;
  logic [7:0]        cnn_q;

  logic              start_ok, last_img, hit_w, wait_expire;
  logic [CNT_W-1:0]  n_clamp;
  logic [CNT_W:0]    idx_inc;

  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign n_clamp  = (num_img > CNT_W'(MAX_IMG)) ? CNT_W'(MAX_IMG) : num_img;
  assign idx_inc  = {1'b0, idx_q} + (CNT_W+1)'(1);
  assign last_img = (idx_inc == {1'b0, n_q});
  assign hit_w    = !to_q && (dec_q == lbl_q);

`ifdef SEQ_TIMEOUT_EN
  assign wait_expire = (state == S_WAIT) && !valid_out && (cyc_q == CYC_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)              timeout_err <= 1'b0;
    else if (start_ok)    timeout_err <= 1'b0;
    else if (wait_expire) timeout_err <= 1'b1;
  end
`else
  assign wait_expire = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = (n_clamp == '0) ? S_DONE : S_CNN_RST;
      S_CNN_RST:      if (cyc_q == CYC_W'(RST_CYC - 1)) state_nx = S_STREAM;
      S_STREAM:       if (cyc_q == CYC_W'(PIX_PER_IMG - 1)) state_nx = S_DRAIN;
      // two cycles let the last pixel traverse the memory and output registers
      S_DRAIN:        if (cyc_q == CYC_W'(1)) state_nx = S_WAIT;
      S_WAIT:         if (valid_out || wait_expire) state_nx = S_SCORE;
      S_SCORE:        state_nx = last_img ? S_DONE : S_CNN_RST;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cyc_q     <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      hit_q     <= '0;
      img_q     <= '0;
      base_q    <= '0;
      lbl_q     <= '0;
      dec_q     <= '0;
      to_q      <= 1'b0;
      rd_d1     <= 1'b0;
      cnn_q     <= '0;
      cnn_rst_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cyc_q     <= (state_nx != state) ? '0 : cyc_q + CYC_W'(1);
      rd_d1     <= (state == S_STREAM);
      cnn_q     <= rd_d1 ? pix_data : 8'h00;
      cnn_rst_q <= (state_nx != S_CNN_RST);

      if (start_ok) begin
        n_q    <= n_clamp;
        idx_q  <= '0;
        base_q <= '0;
        hit_q  <= '0;
        img_q  <= '0;
      end

      if (state == S_CNN_RST) to_q <= 1'b0;
      if (state == S_STREAM) lbl_q <= lbl_data;
      if (state == S_WAIT && valid_out) dec_q <= decision;
      if (wait_expire) to_q <= 1'b1;

      if (state == S_SCORE) begin
        if (img_q < CNT_W'(MAX_IMG)) img_q <= img_q + CNT_W'(1);
        if (hit_w && hit_q < CNT_W'(MAX_IMG)) hit_q <= hit_q + CNT_W'(1);
        if (!last_img) begin
          idx_q  <= idx_inc[CNT_W-1:0];
          base_q <= base_q + ADDR_W'(PIX_PER_IMG);
        end
      end
    end
  end

  assign busy      = !(state == S_IDLE || state == S_DONE);
  assign done      = (state == S_DONE);
  assign pix_rd    = (state == S_STREAM);
  assign pix_addr  = pix_rd ? base_q + ADDR_W'(cyc_q) : '0;
  assign lbl_addr  = idx_q;
  assign cnn_rst_n = cnn_rst_q;
  assign cnn_data  = cnn_q;
  assign res_valid = (state == S_SCORE);
  assign res_hit   = res_valid && hit_w;
  assign res_idx   = res_valid ? idx_q : '0;
  assign hit_cnt   = hit_q;
  assign img_cnt   = img_q;

endmodule

// File: tb/tb_cnn_image_sequencer.sv
// Directed bench for cnn_image_sequencer with pixel/label memory models and a scripted CNN core.
// MAX_IMG is reduced to 4 so the clamp run stays short; TIMEOUT is 64 for the SEQ_TIMEOUT_EN build.
module tb_cnn_image_sequencer;

  localparam int PIX  = 784;
  localparam int MAXI = 4;
  localparam int AW   = 20;
  localparam int CW   = 10;
  localparam int RSTC = 2;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          rst, start, valid_out;
  logic [CW-1:0] num_img;
  logic [7:0]    pix_data;
  logic [3:0]    lbl_data, decision;
  logic          busy, done, pix_rd, cnn_rst_n, res_valid, res_hit, timeout_err;
  logic [AW-1:0] pix_addr;
  logic [CW-1:0] lbl_addr, res_idx, hit_cnt, img_cnt;
  logic [7:0]    cnn_data;

  always #5 clk = ~clk;

  cnn_image_sequencer #(
    .PIX_PER_IMG(PIX), .MAX_IMG(MAXI), .ADDR_W(AW), .CNT_W(CW), .RST_CYC(RSTC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_img(num_img), .busy(busy), .done(done),
    .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data), .lbl_addr(lbl_addr),
    .lbl_data(lbl_data), .cnn_rst_n(cnn_rst_n), .cnn_data(cnn_data), .valid_out(valid_out),
    .decision(decision), .res_valid(res_valid), .res_hit(res_hit), .res_idx(res_idx),
    .hit_cnt(hit_cnt), .img_cnt(img_cnt), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [3:0] lbl_tab [0:7];

  function automatic logic [7:0] pix_fn(input logic [AW-1:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  // one-cycle-latency pixel and label memories
  always @(posedge clk) begin
    pix_data <= pix_fn(pix_addr);
    lbl_data <= lbl_tab[lbl_addr[2:0]];
  end

  int         res_cnt = 0;
  int         res_hit_log [0:63];
  int         res_idx_log [0:63];
  int         burst_cnt = 0, addr_err = 0, prev_addr = 0;
  int         burst_first [0:63];
  int         burst_last  [0:63];
  int         burst_len   [0:63];
  logic       prev_rd = 1'b0;
  int         low_cnt = 0, low_run = 0;
  int         low_len [0:63];
  int         pipe_err = 0;
  logic       rd_h1 = 1'b0, rd_h2 = 1'b0, rst_h1 = 1'b1, rst_h2 = 1'b1;
  logic [AW-1:0] a_h1 = '0, a_h2 = '0;
  logic [7:0] exp_px;

  // passive monitors sampled just after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (res_valid === 1'b1) begin
      res_hit_log[res_cnt & 63] = int'(res_hit);
      res_idx_log[res_cnt & 63] = int'(res_idx);
      res_cnt++;
    end

    if (rst) begin
      if (prev_rd) burst_cnt++;
      prev_rd = 1'b0;
    end else begin
      if (pix_rd === 1'b1) begin
        if (!prev_rd) begin
          burst_first[burst_cnt & 63] = int'(pix_addr);
          burst_len[burst_cnt & 63]   = 0;
        end else if (int'(pix_addr) != prev_addr + 1) begin
          addr_err++;
        end
        burst_len[burst_cnt & 63]++;
        burst_last[burst_cnt & 63] = int'(pix_addr);
      end else if (prev_rd) begin
        burst_cnt++;
      end
      prev_rd   = (pix_rd === 1'b1);
      prev_addr = int'(pix_addr);
    end

    if (rst) low_run = 0;
    else if (cnn_rst_n === 1'b0) low_run++;
    else if (low_run > 0) begin
      low_len[low_cnt & 63] = low_run;
      low_cnt++;
      low_run = 0;
    end

    if (!rst && !rst_h1 && !rst_h2) begin
      exp_px = rd_h2 ? pix_fn(a_h2) : 8'h00;
      if (cnn_data !== exp_px) pipe_err++;
    end
    rst_h2 = rst_h1;  rst_h1 = rst;
    rd_h2  = rd_h1;   rd_h1  = (pix_rd === 1'b1);
    a_h2   = a_h1;    a_h1   = pix_addr;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    start   = 1'b1;
    num_img = CW'(n);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic waitPixRd();
    int k = 0;
    while (pix_rd !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (pix_rd !== 1'b1) checkOutput("pix_rd_rise_bound", pix_rd, 1);
  endtask

  // plays the CNN core for one image; delay < 0 means no valid_out is ever given
  task automatic runImage(input logic [3:0] dec, input int delay, input bit poke);
    int k = 0;
    waitPixRd();
    if (poke) begin
      repeat (5) @(negedge clk);
      start     = 1'b1;
      num_img   = CW'(3);
      valid_out = 1'b1;
      decision  = ~dec;
      @(negedge clk);
      start     = 1'b0;
      valid_out = 1'b0;
    end
    while (pix_rd === 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (pix_rd === 1'b1) checkOutput("pix_rd_fall_bound", pix_rd, 0);
    if (delay >= 0) begin
      repeat (delay) @(negedge clk);
      valid_out = 1'b1;
      decision  = dec;
      @(negedge clk);
      valid_out = 1'b0;
    end
  endtask

  task automatic waitDone(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("done_reached", done, 1);
  endtask

  int r0, b0, l0, k;
  int exp_hit [0:2];
  logic [3:0] dec3 [0:2];

  initial begin
    rst = 1'b1; start = 1'b0; num_img = '0; valid_out = 1'b0; decision = '0;
    for (int i = 0; i < 8; i++) lbl_tab[i] = 4'(i);
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pix_rd", pix_rd, 0);
    checkOutput("rst_cnn_rst_n", cnn_rst_n, 0);
    checkOutput("rst_cnn_data", cnn_data, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_hit_cnt", hit_cnt, 0);
    checkOutput("rst_img_cnt", img_cnt, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_cnn_rst_n", cnn_rst_n, 1);

    $display("[TB] reset during STREAM");
    applyStimulus(2);
    checkOutput("t1_busy", busy, 1);
    waitPixRd();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t1_abort_busy", busy, 0);
    checkOutput("t1_abort_pix_rd", pix_rd, 0);
    checkOutput("t1_abort_cnn_rst_n", cnn_rst_n, 0);
    checkOutput("t1_abort_img_cnt", img_cnt, 0);
    checkOutput("t1_abort_res_valid", res_valid, 0);
    checkOutput("t1_abort_cnn_data", cnn_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t1_release_cnn_rst_n", cnn_rst_n, 1);
    checkOutput("t1_no_results", res_cnt, 0);

    $display("[TB] num_img=0");
    b0 = burst_cnt; l0 = low_cnt;
    applyStimulus(0);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_busy", busy, 0);
    repeat (5) @(negedge clk);
    checkOutput("t2_no_pix_rd", burst_cnt - b0, 0);
    checkOutput("t2_no_core_reset", low_cnt - l0, 0);

    $display("[TB] single image, hit");
    lbl_tab[0] = 4'd7;
    r0 = res_cnt; b0 = burst_cnt; l0 = low_cnt;
    applyStimulus(1);
    checkOutput("t3_done_cleared", done, 0);
    checkOutput("t3_busy", busy, 1);
    runImage(4'd7, 10, 1'b0);
    waitDone(3000);
    checkOutput("t3_res_count", res_cnt - r0, 1);
    checkOutput("t3_res_hit", res_hit_log[r0 & 63], 1);
    checkOutput("t3_res_idx", res_idx_log[r0 & 63], 0);
    checkOutput("t3_hit_cnt", hit_cnt, 1);
    checkOutput("t3_img_cnt", img_cnt, 1);
    checkOutput("t3_busy_end", busy, 0);
    checkOutput("t3_burst_len", burst_len[b0 & 63], PIX);
    checkOutput("t3_burst_first", burst_first[b0 & 63], 0);
    checkOutput("t3_burst_last", burst_last[b0 & 63], PIX - 1);
    checkOutput("t3_core_rst_len", low_len[l0 & 63], RSTC);
    checkOutput("t3_pipe_err", pipe_err, 0);

    $display("[TB] three images");
    lbl_tab[0] = 4'd2; lbl_tab[1] = 4'd5; lbl_tab[2] = 4'd9;
    dec3[0] = 4'd2; dec3[1] = 4'd4; dec3[2] = 4'd9;
    exp_hit[0] = 1; exp_hit[1] = 0; exp_hit[2] = 1;
    r0 = res_cnt; b0 = burst_cnt; l0 = low_cnt;
    applyStimulus(3);
    checkOutput("t4_hit_cnt_cleared", hit_cnt, 0);
    for (int i = 0; i < 3; i++) runImage(dec3[i], 10 + 3 * i, 1'b0);
    waitDone(3000);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t4_res_hit%0d", i), res_hit_log[(r0 + i) & 63], exp_hit[i]);
      checkOutput($sformatf("t4_res_idx%0d", i), res_idx_log[(r0 + i) & 63], i);
      checkOutput($sformatf("t4_core_rst_len%0d", i), low_len[(l0 + i) & 63], RSTC);
    end
    checkOutput("t4_hit_cnt", hit_cnt, 2);
    checkOutput("t4_img_cnt", img_cnt, 3);
    checkOutput("t4_core_rst_count", low_cnt - l0, 3);
    checkOutput("t4_img1_first", burst_first[(b0 + 1) & 63], 784);
    checkOutput("t4_img2_first", burst_first[(b0 + 2) & 63], 1568);
    checkOutput("t4_img2_last", burst_last[(b0 + 2) & 63], 2351);
    checkOutput("t4_addr_err", addr_err, 0);

    $display("[TB] num_img clamp");
    for (int i = 0; i < 4; i++) lbl_tab[i] = 4'(i + 3);
    r0 = res_cnt;
    applyStimulus(1023);
    for (int i = 0; i < 4; i++) runImage(4'(i + 3), 4, 1'b0);
    waitDone(3000);
    checkOutput("t5_img_cnt", img_cnt, MAXI);
    checkOutput("t5_hit_cnt", hit_cnt, MAXI);
    checkOutput("t5_res_count", res_cnt - r0, MAXI);
    checkOutput("t5_last_idx", res_idx_log[(r0 + 3) & 63], MAXI - 1);

    $display("[TB] start and valid_out during STREAM");
    lbl_tab[0] = 4'hA;
    r0 = res_cnt;
    applyStimulus(1);
    runImage(4'hA, 6, 1'b1);
    waitDone(3000);
    checkOutput("t6_res_count", res_cnt - r0, 1);
    checkOutput("t6_res_hit", res_hit_log[r0 & 63], 1);
    checkOutput("t6_img_cnt", img_cnt, 1);
    checkOutput("t6_hit_cnt", hit_cnt, 1);
    checkOutput("t6_pipe_err", pipe_err, 0);

`ifdef SEQ_TIMEOUT_EN
    $display("[TB] WAIT watchdog");
    lbl_tab[0] = 4'd1; lbl_tab[1] = 4'd6;
    r0 = res_cnt;
    applyStimulus(2);
    runImage(4'd1, -1, 1'b0);
    k = 0;
    while (res_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t7_timeout_latency", k, TMO + 2);
    checkOutput("t7_res_hit", res_hit, 0);
    checkOutput("t7_timeout_err", timeout_err, 1);
    checkOutput("t7_res_idx", res_idx, 0);
    runImage(4'd6, 8, 1'b0);
    waitDone(3000);
    checkOutput("t7_hit_cnt", hit_cnt, 1);
    checkOutput("t7_img_cnt", img_cnt, 2);
    checkOutput("t7_timeout_sticky", timeout_err, 1);
    checkOutput("t7_res_count", res_cnt - r0, 2);
`else
    checkOutput("t7_timeout_err_tied", timeout_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
